// File: rtl/deco_reg_load_ctrl.sv
// Steers a three-digit stream into slot1..slot3 of a register bank via a one-hot write strobe.
// Rejects out-of-range digits, aborts on idle timeout or cancel, and flags done/err as pulses.
module deco_reg_load_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_DIGIT = 9,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic [1:0]       slot_sel,
    output logic [2:0]       wr_en,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned     TimerW   = $clog2(TIMEOUT);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCommit, StAbort} state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    logic                xfer;
    logic                in_range;

    assign din_ready = (state_q == StLoad);
    assign xfer      = din_valid && din_ready;
    assign in_range  = (32'(din) <= MAX_DIGIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            slot_sel <= 2'b00;
            wr_en    <= 3'b000;
            dout     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Strobes and pulses default low; only the branches below raise them.
            wr_en <= 3'b000;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StLoad;
                        slot_sel <= 2'b01;
                        timer_q  <= '0;
                        busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (cancel) begin
                        state_q  <= StAbort;
                        slot_sel <= 2'b00;
                        err      <= 1'b1;
                    end else if (xfer) begin
                        timer_q <= '0;
                        if (in_range) begin
                            dout <= din;
                            case (slot_sel)
                                2'b01: begin
                                    wr_en    <= 3'b100;
                                    slot_sel <= 2'b10;
                                end
                                2'b10: begin
                                    wr_en    <= 3'b010;
                                    slot_sel <= 2'b11;
                                end
                                2'b11: begin
                                    wr_en    <= 3'b001;
                                    slot_sel <= 2'b00;
                                    done     <= 1'b1;
                                    state_q  <= StCommit;
                                end
                                default: begin
                                    slot_sel <= 2'b00;
                                    state_q  <= StAbort;
                                    err      <= 1'b1;
                                end
                            endcase
                        end else begin
                            // Rejected digit: same slot is retried.
                            err <= 1'b1;
                        end
                    end else if (timer_q == TimerMax) begin
                        state_q  <= StAbort;
                        slot_sel <= 2'b00;
                        err      <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                StAbort: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    slot_sel <= 2'b00;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deco_reg_load_ctrl.sv
// Directed bench for deco_reg_load_ctrl: an entry-level behavioural model checked every cycle,
// plus literal expectations for each scenario.
module tb_deco_reg_load_ctrl;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned TIMEOUT   = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             cancel;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             din_ready;
    logic [1:0]       slot_sel;
    logic [2:0]       wr_en;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic             err;

    int checks   = 0;
    int failures = 0;

    // Bank contents as written by the DUT strobes.
    logic [WIDTH-1:0] bank [3];

    deco_reg_load_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_DIGIT(MAX_DIGIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cancel   (cancel),
        .din_valid(din_valid),
        .din      (din),
        .din_ready(din_ready),
        .slot_sel (slot_sel),
        .wr_en    (wr_en),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an entry is "open" while digits are collected, then "wrapping" for one cycle.
    bit         m_open;
    bit         m_wrap;
    int         m_filled;
    int         m_quiet;
    logic [2:0] m_wr;
    int         m_dout;
    bit         m_done;
    bit         m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_open = 0; m_wrap = 0; m_filled = 0; m_quiet = 0;
            m_wr = 3'b000; m_dout = 0; m_done = 0; m_err = 0;
        end else begin
            m_wr = 3'b000; m_done = 0; m_err = 0;
            if (m_wrap) begin
                m_wrap = 0;
            end else if (!m_open) begin
                if (start) begin
                    m_open = 1; m_filled = 0; m_quiet = 0;
                end
            end else if (cancel) begin
                m_open = 0; m_wrap = 1; m_err = 1;
            end else if (din_valid) begin
                m_quiet = 0;
                if (int'(din) <= MAX_DIGIT) begin
                    m_dout = int'(din);
                    m_wr = 3'b100 >> m_filled;
                    m_filled++;
                    if (m_filled == 3) begin
                        m_open = 0; m_wrap = 1; m_done = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    m_open = 0; m_wrap = 1; m_err = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare();
        int exp_slot;
        exp_slot = m_open ? m_filled + 1 : 0;
        chk("din_ready", 32'(din_ready), 32'(m_open));
        chk("slot_sel", 32'(slot_sel), 32'(exp_slot));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("busy", 32'(busy), 32'(m_open || m_wrap));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("inv_onehot", 32'($onehot0(wr_en)), 32'd1);
        if (wr_en[2]) bank[0] = dout;
        if (wr_en[1]) bank[1] = dout;
        if (wr_en[0]) bank[2] = dout;
    endtask

    task automatic cyc(input logic s, input logic c, input logic v, input logic [WIDTH-1:0] d);
        start = s; cancel = c; din_valid = v; din = d;
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; din_valid = 1'b0; din = '0;
        for (int i = 0; i < 3; i++) bank[i] = '0;
        repeat (2) @(negedge clk);
        compare();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);

        // Three good digits, din_valid held.
        cyc(1, 0, 0, 0);  chk("t1_sel", 32'(slot_sel), 32'd1);
        cyc(0, 0, 1, 3);  chk("t1_wr1", 32'(wr_en), 32'b100); chk("t1_d1", 32'(dout), 32'd3);
        cyc(0, 0, 1, 5);  chk("t1_wr2", 32'(wr_en), 32'b010); chk("t1_d2", 32'(dout), 32'd5);
        cyc(0, 0, 1, 7);  chk("t1_wr3", 32'(wr_en), 32'b001); chk("t1_done", 32'(done), 32'd1);
        chk("t1_sel3", 32'(slot_sel), 32'd0); chk("t1_busy3", 32'(busy), 32'd1);
        cyc(0, 0, 0, 0);  chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_bank", {20'd0, bank[0], bank[1], bank[2]}, 32'h357);

        // Out-of-range digit retried on the same slot.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 2);  chk("t2_wr1", 32'(wr_en), 32'b100);
        cyc(0, 0, 1, 12); chk("t2_err", 32'(err), 32'd1); chk("t2_wr0", 32'(wr_en), 32'd0);
        chk("t2_sel", 32'(slot_sel), 32'b10);
        cyc(0, 0, 1, 4);  chk("t2_wr2", 32'(wr_en), 32'b010); chk("t2_d2", 32'(dout), 32'd4);
        cyc(0, 0, 1, 6);  chk("t2_done", 32'(done), 32'd1);
        cyc(0, 0, 0, 0);
        chk("t2_bank", {20'd0, bank[0], bank[1], bank[2]}, 32'h246);

        // Idle timeout after one digit.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);  chk("t3_wr1", 32'(wr_en), 32'b100);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
        chk("t3_noerr", 32'(err), 32'd0); chk("t3_busy7", 32'(busy), 32'd1);
        cyc(0, 0, 0, 0);  chk("t3_err", 32'(err), 32'd1); chk("t3_sel", 32'(slot_sel), 32'd0);
        cyc(0, 0, 0, 0);  chk("t3_idle", 32'(busy), 32'd0); chk("t3_err_once", 32'(err), 32'd0);
        chk("t3_bank", {20'd0, bank[0], bank[1], bank[2]}, 32'h146);

        // Cancel wins over a valid digit; start during LOAD ignored.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 5);  chk("t4_wr1", 32'(wr_en), 32'b100);
        cyc(1, 1, 1, 6);  chk("t4_err", 32'(err), 32'd1); chk("t4_wr0", 32'(wr_en), 32'd0);
        chk("t4_dout", 32'(dout), 32'd5);
        cyc(0, 0, 0, 0);  chk("t4_idle", 32'(busy), 32'd0);
        cyc(0, 1, 1, 3);  chk("t4_still", 32'(busy), 32'd0);
        cyc(0, 0, 0, 0);  chk("t4_ign", 32'(wr_en), 32'd0);
        chk("t4_bank", {20'd0, bank[0], bank[1], bank[2]}, 32'h546);

        // Asynchronous reset mid-entry.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 8);  chk("t5_wr1", 32'(wr_en), 32'b100);
        din_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t5_wr", 32'(wr_en), 32'd0);  chk("t5_sel", 32'(slot_sel), 32'd0);
        chk("t5_dout", 32'(dout), 32'd0); chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        compare();
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);  chk("t5_resume", 32'(slot_sel), 32'd1);
        cyc(0, 0, 1, 2);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 4);  chk("t5_done", 32'(done), 32'd1);

        // Back-to-back: start during COMMIT ignored, accepted in the following IDLE cycle.
        cyc(1, 0, 0, 0);  chk("t6_gap_rdy", 32'(din_ready), 32'd0); chk("t6_gap", 32'(busy), 32'd0);
        cyc(1, 0, 0, 0);  chk("t6_sel", 32'(slot_sel), 32'd1);
        cyc(0, 0, 1, 0);  chk("t6_d1", 32'(dout), 32'd0);
        cyc(0, 0, 1, 9);  chk("t6_max", 32'(wr_en), 32'b010);
        cyc(0, 0, 1, 10); chk("t6_rej", 32'(err), 32'd1); chk("t6_sel3", 32'(slot_sel), 32'b11);
        cyc(0, 0, 1, 9);  chk("t6_done", 32'(done), 32'd1);
        cyc(0, 0, 0, 0);
        chk("t6_bank", {20'd0, bank[0], bank[1], bank[2]}, 32'h099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deco_reg_load_ctrl.md
Name: deco_reg_load_ctrl

Overview:
- Sequencer that loads a 3-slot parallel register bank (slot1, slot2, slot3) from a single digit stream, e.g. a keypad entry.
- Accepts WIDTH-bit digits over a valid/ready handshake and steers each digit to the next slot through a one-hot write enable.
- Range-checks each digit, aborts on timeout or cancel, and reports completion or error with one-cycle pulses.
- Sits between the input source and the decoder/register bank.

Parameters:
WIDTH, 4, digit width and width of dout
MAX_DIGIT, 9, largest accepted digit value; larger values are rejected
TIMEOUT, 1000, idle cycles allowed between accepted digits before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a 3-digit entry; sampled only in IDLE
cancel  in  1  abort entry in progress
din_valid  in  1  din holds a digit
din  in  WIDTH  digit value
din_ready  out  1  controller accepts a digit this cycle
slot_sel  out  2  current target slot: 00 none, 01 slot1, 10 slot2, 11 slot3
wr_en  out  3  one-hot write strobe: [2] slot1, [1] slot2, [0] slot3
dout  out  WIDTH  data for the strobed slot
busy  out  1  entry in progress (state != IDLE)
done  out  1  one-cycle pulse, all three slots written
err  out  1  one-cycle pulse on rejected digit, timeout or cancel

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, slot_sel=00, wr_en=000, dout=0, din_ready=0, busy=0, done=0, err=0, timer=0.
- All outputs are registered. din_ready is driven combinationally from state: it is 1 only in LOAD.
- States: IDLE, LOAD, COMMIT, ABORT.
- IDLE: start=1 -> LOAD next cycle, slot_sel=01, timer=0. cancel and din_valid are ignored.
- LOAD: a transfer occurs when din_valid && din_ready.
  - Digit in range (din<=MAX_DIGIT): the next cycle has dout=din and exactly one wr_en bit set for the current slot_sel, for one cycle. slot_sel advances 01->10->11. timer clears.
  - Third digit accepted: -> COMMIT.
  - Digit out of range: no wr_en, err pulses the next cycle, slot_sel unchanged (the same slot is retried), timer clears.
  - No transfer: timer increments. When timer reaches TIMEOUT-1 -> ABORT.
- Priority in the same LOAD cycle: cancel > transfer > timeout. cancel together with din_valid discards the digit, with no wr_en.
- COMMIT (1 cycle): wr_en[0]=1 with the third digit on dout, done=1, slot_sel=00. -> IDLE.
- ABORT (1 cycle): err=1, slot_sel=00, wr_en=000. -> IDLE.
  - Slots already written keep their values; there is no rollback.
- wr_en and done/err are cleared every cycle they are not explicitly asserted. dout holds its last written value between writes.
- start in LOAD, COMMIT or ABORT is ignored. start is not queued.
- reset asserted mid-entry returns immediately to the reset values; a partial entry is lost.
- Invariants:
  - wr_en is never multi-hot.
  - done and err are never high together.
  - din_ready=0 in every state except LOAD.

Test Plan:
- Reset, start, digits 3,5,7 with din_valid held 1 -> wr_en 100/010/001 on three consecutive cycles, each one cycle after its acceptance, with dout 3/5/7; done=1 in the wr_en=001 cycle; busy falls the cycle after.
- Start, digit 2, then digit 12 (>MAX_DIGIT), then 4, 6 -> err pulse after 12 with no wr_en and slot_sel staying 10; 4 goes to slot2, 6 to slot3; done pulses.
- TIMEOUT=8: start, digit 1, then din_valid=0 -> ABORT on the 8th idle cycle; err pulses once; slot_sel=00; slot1 keeps 1; no done.
- Start, digit 5, then cancel=1 with din_valid=1 and din=6 in the same cycle -> no wr_en for 6, err pulses, IDLE; start pulsed during that LOAD has no effect.
- Drop reset to 0 during LOAD after one digit -> all outputs go to reset values without waiting for a clock edge; after reset release, a new start resumes at slot_sel=01.
- Back-to-back entries: start one cycle after done -> second entry begins normally; din_ready stays 0 in the IDLE cycle between entries.
